// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: streams filter/ifmap pairs into one PE, then waits for
// the PE and captures its output psum as the job result.
//
// Ports:
//   clk, rstb          clock, synchronous active-low reset
//   start, num_taps    job request and filter/ifmap pair count
//   psum_in            partial sum latched on an accepted start
//   src_valid/ready    word stream handshake, src_data ordered f0,i0,f1,i1,...
//   pe_*               write strobes, words and psum toward the PE;
//                      pe_ready/pe_output_psum come back from it
//   busy               any state other than IDLE
//   result(_valid)     captured PE psum and its one-cycle update pulse
//   cfg_error          pulse: start with an illegal num_taps
//   timeout_error      pulse: PE did not finish in TIMEOUT_CYCLES
module pe_load_sequencer #(
  parameter int BITWIDTH       = 16,
  parameter int RF_ADDR_WIDTH  = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     start,
  input  logic [RF_ADDR_WIDTH:0]   num_taps,
  input  logic [BITWIDTH-1:0]      psum_in,
  input  logic                     src_valid,
  input  logic [BITWIDTH-1:0]      src_data,
  output logic                     src_ready,
  output logic                     pe_filter_enable,
  output logic                     pe_ifmap_enable,
  output logic [BITWIDTH-1:0]      pe_filter,
  output logic [BITWIDTH-1:0]      pe_ifmap,
  output logic [BITWIDTH-1:0]      pe_input_psum,
  input  logic                     pe_ready,
  input  logic [BITWIDTH-1:0]      pe_output_psum,
  output logic                     busy,
  output logic [BITWIDTH-1:0]      result,
  output logic                     result_valid,
  output logic                     cfg_error,
  output logic                     timeout_error
);

  localparam int NW = RF_ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NW-1:0] MAX_TAPS =
    NW'(1) << RF_ADDR_WIDTH;
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    LOAD_I,
    WAIT_PE,
    CAPTURE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NW-1:0] tap_cnt;
  logic [NW-1:0] taps_q;
  logic [NW-1:0] tap_inc;
  logic [TW-1:0] timer;

  logic cfg_ok;
  logic last_tap;
  logic timer_done;

  logic load_job;
  logic filter_we;
  logic ifmap_we;
  logic cfg_err_d;
  logic tmo_d;
  logic cap_d;

  assign cfg_ok     = (num_taps != '0) &&
                      (num_taps <= MAX_TAPS);
  assign tap_inc    = tap_cnt + NW'(1);
  assign last_tap   = (tap_inc == taps_q);
  // Timer holds 0 outside WAIT_PE, so it
  // equals the count of WAIT_PE edges seen.
  assign timer_done = (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          state_nx = LOAD_F;
        end
      end
      LOAD_F: begin
        if (src_valid) begin
          state_nx = LOAD_I;
        end
      end
      LOAD_I: begin
        if (src_valid) begin
          state_nx = last_tap ? WAIT_PE : LOAD_F;
        end
      end
      WAIT_PE: begin
        // pe_ready wins over an expiring timer
        if (pe_ready) begin
          state_nx = CAPTURE;
        end else if (timer_done) begin
          state_nx = IDLE;
        end
      end
      CAPTURE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    src_ready = 1'b0;
    busy      = 1'b1;
    load_job  = 1'b0;
    filter_we = 1'b0;
    ifmap_we  = 1'b0;
    cfg_err_d = 1'b0;
    tmo_d     = 1'b0;
    cap_d     = 1'b0;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        load_job  = start && cfg_ok;
        cfg_err_d = start && !cfg_ok;
      end
      LOAD_F: begin
        src_ready = 1'b1;
        filter_we = src_valid;
      end
      LOAD_I: begin
        src_ready = 1'b1;
        ifmap_we  = src_valid;
      end
      WAIT_PE: begin
        tmo_d = !pe_ready && timer_done;
      end
      CAPTURE: begin
        cap_d = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      pe_filter_enable <= 1'b0;
      pe_ifmap_enable  <= 1'b0;
      pe_filter        <= '0;
      pe_ifmap         <= '0;
      pe_input_psum    <= '0;
      taps_q           <= '0;
      tap_cnt          <= '0;
      timer            <= '0;
      result           <= '0;
      result_valid     <= 1'b0;
      cfg_error        <= 1'b0;
      timeout_error    <= 1'b0;
    end else begin
      pe_filter_enable <= filter_we;
      pe_ifmap_enable  <= ifmap_we;
      if (filter_we) begin
        pe_filter <= src_data;
      end
      if (ifmap_we) begin
        pe_ifmap <= src_data;
      end

      if (load_job) begin
        taps_q        <= num_taps;
        pe_input_psum <= psum_in;
        tap_cnt       <= '0;
      end else if (ifmap_we) begin
        tap_cnt <= tap_inc;
      end

      if (state != WAIT_PE) begin
        timer <= '0;
      end else if (!timer_done) begin
        timer <= timer + TW'(1);
      end

      cfg_error     <= cfg_err_d;
      timeout_error <= tmo_d;
      result_valid  <= cap_d;
      if (cap_d) begin
        result <= pe_output_psum;
      end
    end
  end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Bench for pe_load_sequencer: behavioural PE stand-in, strobe and
// result scoreboards, one task per scenario.
module tb_pe_load_sequencer;

  localparam int BW  = 16;
  localparam int AW  = 3;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_taps = '0;
  logic [BW-1:0] psum_in = '0;
  logic          src_valid = 1'b0;
  logic [BW-1:0] src_data = '0;
  logic          src_ready;
  logic          pe_filter_enable;
  logic          pe_ifmap_enable;
  logic [BW-1:0] pe_filter;
  logic [BW-1:0] pe_ifmap;
  logic [BW-1:0] pe_input_psum;
  logic          pe_ready;
  logic [BW-1:0] pe_output_psum;
  logic          busy;
  logic [BW-1:0] result;
  logic          result_valid;
  logic          cfg_error;
  logic          timeout_error;

  pe_load_sequencer #(
    .BITWIDTH(BW),
    .RF_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .start(start),
    .num_taps(num_taps),
    .psum_in(psum_in),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .pe_filter_enable(pe_filter_enable),
    .pe_ifmap_enable(pe_ifmap_enable),
    .pe_filter(pe_filter),
    .pe_ifmap(pe_ifmap),
    .pe_input_psum(pe_input_psum),
    .pe_ready(pe_ready),
    .pe_output_psum(pe_output_psum),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .cfg_error(cfg_error),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit            is_if;
    logic [BW-1:0] val;
  } strobe_t;

  strobe_t       sq[$];
  logic [BW-1:0] rq[$];
  logic [BW-1:0] exp_psum = '0;

  int n_strobe = 0;
  int n_rv = 0;
  int n_cfg = 0;
  int n_tmo = 0;
  int last_strobe_cyc = 0;
  int tmo_cyc = 0;
  int start_cyc = 0;

  int fv[8];
  int iv[8];

  // PE stand-in: multiply-accumulate on strobes, ready after pe_dly cycles
  bit pe_mdl_clr = 1'b1;
  bit pe_auto = 1'b1;
  int pe_dly = 3;
  int mdl_taps = 0;
  int f_q, acc_m, cnt_m, dly_m, tmp_m;

  always @(negedge clk) begin
    if (pe_mdl_clr) begin
      f_q = 0;
      acc_m = 0;
      cnt_m = 0;
      dly_m = 0;
      pe_ready = 1'b0;
      pe_output_psum = '0;
    end else begin
      if (pe_filter_enable) f_q = int'($signed(pe_filter));
      if (pe_ifmap_enable) begin
        acc_m += f_q * int'($signed(pe_ifmap));
        cnt_m++;
      end
      if (pe_auto && cnt_m == mdl_taps && cnt_m != 0 && !pe_ready) begin
        if (dly_m >= pe_dly) begin
          tmp_m = acc_m + int'($signed(pe_input_psum));
          pe_ready = 1'b1;
          pe_output_psum = tmp_m[BW-1:0];
        end else begin
          dly_m++;
        end
      end
    end
  end

  // Monitor: pops scoreboards as the DUT produces strobes and results
  always @(negedge clk) begin
    strobe_t e;
    logic [BW-1:0] r;
    logic [BW-1:0] got;
    if (pe_filter_enable || pe_ifmap_enable) begin
      n_strobe++;
      last_strobe_cyc = cyc;
      vectors++;
      if ((pe_filter_enable && pe_ifmap_enable) !== 1'b0) begin
        miscompares++;
        $display("FAIL dual_strobe: both strobes high at cycle %0d", cyc);
      end
      vectors++;
      if (sq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: f=%0b i=%0b at cycle %0d",
                 pe_filter_enable, pe_ifmap_enable, cyc);
      end else begin
        e = sq.pop_front();
        got = e.is_if ? pe_ifmap : pe_filter;
        if (pe_ifmap_enable !== e.is_if || got !== e.val) begin
          miscompares++;
          $display("FAIL strobe: got ifmap=%0b val=%0d, want ifmap=%0b val=%0d",
                   pe_ifmap_enable, got, e.is_if, e.val);
        end
      end
      vectors++;
      if (pe_input_psum !== exp_psum) begin
        miscompares++;
        $display("FAIL input_psum: got %0d want %0d", pe_input_psum, exp_psum);
      end
    end
    if (result_valid) begin
      n_rv++;
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result: result=%0d", result);
      end else begin
        r = rq.pop_front();
        if (result !== r) begin
          miscompares++;
          $display("FAIL result: got %0d want %0d", $signed(result), $signed(r));
        end
      end
    end
    if (cfg_error) n_cfg++;
    if (timeout_error) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
  end

  function automatic logic [BW-1:0] exp_res(input int taps, input int ps);
    int acc;
    acc = ps;
    for (int k = 0; k < taps; k++) acc += fv[k] * iv[k];
    return acc[BW-1:0];
  endfunction

  task automatic do_start(input int taps, input int ps);
    start = 1'b1;
    num_taps = taps[AW:0];
    psum_in = ps[BW-1:0];
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_job(input int taps, input int ps);
    pe_mdl_clr = 1'b1;
    mdl_taps = taps;
    exp_psum = ps[BW-1:0];
    @(posedge clk); #1;
    pe_mdl_clr = 1'b0;
    do_start(taps, ps);
  endtask

  task automatic send_word(input bit is_if, input int w);
    strobe_t s;
    bit ok;
    s.is_if = is_if;
    s.val = w[BW-1:0];
    sq.push_back(s);
    src_valid = 1'b1;
    src_data = w[BW-1:0];
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ok = src_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    src_valid = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++;
      $display("FAIL src_ready_wait: got %0b want 1", ok);
    end
  endtask

  task automatic stream(input int taps, input int gap);
    for (int k = 0; k < taps; k++) begin
      send_word(1'b0, fv[k]);
      repeat (gap) begin @(posedge clk); #1; end
      send_word(1'b1, iv[k]);
      if (k < taps - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_rv(input int n0, output bit got);
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n_rv != n0) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if ({busy, src_ready, pe_filter_enable, pe_ifmap_enable, result_valid,
         cfg_error, timeout_error} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, src_ready,
               pe_filter_enable, pe_ifmap_enable, result_valid, cfg_error,
               timeout_error});
    end
    vectors++;
    if ({pe_filter, pe_ifmap, pe_input_psum, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: f=%0d i=%0d p=%0d r=%0d want 0",
               pe_filter, pe_ifmap, pe_input_psum, result);
    end
    rstb = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input int gap);
    int s0, r0;
    bit got;
    for (int k = 0; k < 3; k++) begin
      fv[k] = k + 1;
      iv[k] = k + 1;
    end
    s0 = n_strobe;
    r0 = n_rv;
    pe_dly = 3;
    begin_job(3, 5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %0b want 1", busy);
    end
    rq.push_back(exp_res(3, 5));
    stream(3, gap);
    wait_rv(r0, got);
    vectors++;
    if (got !== 1'b1) begin
      miscompares++;
      $display("FAIL result_wait gap=%0d: no result_valid", gap);
    end
    vectors++;
    if (result !== 16'd19) begin
      miscompares++;
      $display("FAIL result_19 gap=%0d: got %0d want 19", gap, result);
    end
    vectors++;
    if (n_strobe - s0 !== 6) begin
      miscompares++;
      $display("FAIL strobe_count gap=%0d: got %0d want 6", gap, n_strobe - s0);
    end
    if (gap == 0) begin
      vectors++;
      if (last_strobe_cyc - start_cyc !== 7) begin
        miscompares++;
        $display("FAIL latency: got %0d want 7", last_strobe_cyc - start_cyc);
      end
    end
    vectors++;
    if (busy !== 1'b0 || n_rv - r0 !== 1) begin
      miscompares++;
      $display("FAIL job_end: busy=%0b pulses=%0d want 0/1", busy, n_rv - r0);
    end
  endtask

  task automatic test_cfg_error;
    int bad[2];
    bad[0] = 0;
    bad[1] = 9;
    for (int j = 0; j < 2; j++) begin
      start = 1'b1;
      num_taps = bad[j][AW:0];
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cfg_error, busy} !== 2'b10) begin
        miscompares++;
        $display("FAIL cfg_pulse taps=%0d: got err/busy %b want 10",
                 bad[j], {cfg_error, busy});
      end
      @(negedge clk);
      vectors++;
      if ({cfg_error, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL cfg_clear taps=%0d: got err/busy %b want 00",
                 bad[j], {cfg_error, busy});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    logic [BW-1:0] r_before;
    int r0, t0;
    bit got;
    fv[0] = 2; iv[0] = 3;
    fv[1] = 4; iv[1] = 5;
    r_before = result;
    r0 = n_rv;
    t0 = n_tmo;
    pe_auto = 1'b0;
    begin_job(2, 7);
    stream(2, 0);
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (n_tmo != t0) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (got !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_seen: no timeout_error");
    end
    vectors++;
    if (tmo_cyc - last_strobe_cyc !== TMO) begin
      miscompares++;
      $display("FAIL timeout_cycles: got %0d want %0d",
               tmo_cyc - last_strobe_cyc, TMO);
    end
    vectors++;
    if (busy !== 1'b0 || result !== r_before || n_rv !== r0) begin
      miscompares++;
      $display("FAIL timeout_state: busy=%0b result=%0d rv=%0d want 0/%0d/%0d",
               busy, result, n_rv, r_before, r0);
    end
    pe_auto = 1'b1;
  endtask

  task automatic test_ready_at_expiry;
    int r0, t0;
    bit got;
    fv[0] = 2; iv[0] = 3;
    r0 = n_rv;
    t0 = n_tmo;
    pe_dly = TMO - 1;
    begin_job(1, 0);
    rq.push_back(exp_res(1, 0));
    stream(1, 0);
    wait_rv(r0, got);
    vectors++;
    if (got !== 1'b1 || n_tmo !== t0) begin
      miscompares++;
      $display("FAIL ready_at_expiry: rv=%0b timeouts=%0d want 1/%0d",
               got, n_tmo, t0);
    end
    vectors++;
    if (result !== 16'd6) begin
      miscompares++;
      $display("FAIL ready_at_expiry_result: got %0d want 6", result);
    end
    pe_dly = 3;
  endtask

  task automatic test_mid_reset;
    int r0;
    bit got;
    fv[0] = 4; iv[0] = 1;
    fv[1] = 5; iv[1] = 1;
    fv[2] = 6; iv[2] = 1;
    r0 = n_rv;
    begin_job(3, 1);
    send_word(1'b0, fv[0]);
    send_word(1'b1, iv[0]);
    send_word(1'b0, fv[1]);
    rstb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({busy, src_ready, pe_filter_enable, pe_ifmap_enable, result_valid,
         cfg_error, timeout_error} !== 7'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: got %b want 0", {busy, src_ready,
               pe_filter_enable, pe_ifmap_enable, result_valid, cfg_error,
               timeout_error});
    end
    vectors++;
    if ({pe_filter, pe_ifmap, pe_input_psum, result} !== '0) begin
      miscompares++;
      $display("FAIL midreset_data: f=%0d i=%0d p=%0d r=%0d want 0",
               pe_filter, pe_ifmap, pe_input_psum, result);
    end
    rstb = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (sq.size() !== 0 || n_rv !== r0) begin
      miscompares++;
      $display("FAIL midreset_leftover: queue=%0d rv=%0d want 0/%0d",
               sq.size(), n_rv, r0);
    end
    fv[0] = -3; iv[0] = 4;
    fv[1] = 7;  iv[1] = 2;
    r0 = n_rv;
    begin_job(2, -10);
    rq.push_back(exp_res(2, -10));
    stream(2, 0);
    wait_rv(r0, got);
    vectors++;
    if (got !== 1'b1 || result !== 16'hFFF8) begin
      miscompares++;
      $display("FAIL after_reset_job: rv=%0b result=%0d want 1/-8",
               got, $signed(result));
    end
  endtask

  task automatic test_full_rf;
    int s0, r0, c0;
    bit got;
    for (int k = 0; k < 8; k++) begin
      fv[k] = k + 1;
      iv[k] = 3 - k;
    end
    s0 = n_strobe;
    r0 = n_rv;
    c0 = n_cfg;
    begin_job(8, 100);
    rq.push_back(exp_res(8, 100));
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        start = 1'b1;
        num_taps = 4'd1;
      end
      send_word(1'b0, fv[k]);
      start = 1'b0;
      send_word(1'b1, iv[k]);
    end
    wait_rv(r0, got);
    vectors++;
    if (got !== 1'b1 || n_rv - r0 !== 1) begin
      miscompares++;
      $display("FAIL full_rf_rv: got %0d pulses want 1", n_rv - r0);
    end
    vectors++;
    if (n_strobe - s0 !== 16) begin
      miscompares++;
      $display("FAIL full_rf_strobes: got %0d want 16", n_strobe - s0);
    end
    vectors++;
    if (n_cfg !== c0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rf_end: cfg=%0d busy=%0b want %0d/0", n_cfg, busy, c0);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic(0);
    test_basic(2);
    test_cfg_error();
    test_timeout();
    test_ready_at_expiry();
    test_mid_reset();
    test_full_rf();
    repeat (4) begin @(posedge clk); #1; end
    vectors++;
    if (sq.size() !== 0 || rq.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: strobes=%0d results=%0d want 0/0",
               sq.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
